// File: rtl/id_decode_pipe_if.sv
// Fetch-to-decode and decode-to-EX handshake bundle for id_decode_pipe.
// master = surrounding pipeline (fetch/EX side), slave = the decode stage.
interface id_decode_pipe_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0]  in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_pc;
  logic [4:0]         out_rs;
  logic [4:0]         out_rt;
  logic [4:0]         out_rd;
  logic [DATA_W-1:0]  out_imm;
  logic               out_alu_src_b;
  logic               out_reg_write;
  logic               out_dst_rt;
  logic               out_mem_read;
  logic               out_mem_write;
  logic               out_branch;
  logic               out_jump;
  logic               out_illegal;
  logic [CNT_W-1:0]   illegal_cnt;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs, out_rt, out_rd, out_imm,
           out_alu_src_b, out_reg_write, out_dst_rt, out_mem_read,
           out_mem_write, out_branch, out_jump, out_illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs, out_rt, out_rd, out_imm,
           out_alu_src_b, out_reg_write, out_dst_rt, out_mem_read,
           out_mem_write, out_branch, out_jump, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/id_decode_pipe.sv
// Two-stage pipelined instruction decode: stage A latches the fetched word,
// stage B holds the registered decoded bundle presented to EX.
module id_decode_pipe #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 8
) (
  input logic           clk,
  input logic           rst,
  id_decode_pipe_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic aluSrcB;
    logic regWrite;
    logic dstRt;
    logic memRead;
    logic memWrite;
    logic branch;
    logic jump;
    logic illegal;
  } ctrlT;

  logic               aValid;
  logic [INSTR_W-1:0] aInstr;
  logic [DATA_W-1:0]  aPc;

  logic               bAdvance;
  logic               inReady;
  logic [5:0]         opcode;
  logic [4:0]         rs, rt, rd, destReg;
  logic [15:0]        imm16;
  logic               zeroExt;
  ctrlT               dec;
  logic [DATA_W-1:0]  immExt;

  // Handshake: B drains when empty or EX takes it; A refills when B drains or A is empty.
  always_comb begin
    bAdvance = !bus.out_valid || bus.out_ready;
    inReady  = !aValid || bAdvance;
  end

  assign bus.in_ready = inReady;

  // Field split and control decode of the instruction held in stage A.
  always_comb begin
    opcode  = aInstr[31:26];
    rs      = aInstr[25:21];
    rt      = aInstr[20:16];
    rd      = aInstr[15:11];
    imm16   = aInstr[15:0];
    dec     = '0;
    zeroExt = 1'b0;
    case (opcode)
      OP_RTYPE: dec.regWrite = 1'b1;
      OP_ADDI: begin
        dec.regWrite = 1'b1;
        dec.dstRt    = 1'b1;
        dec.aluSrcB  = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        dec.regWrite = 1'b1;
        dec.dstRt    = 1'b1;
        dec.aluSrcB  = 1'b1;
        zeroExt      = 1'b1;
      end
      OP_LW: begin
        dec.memRead  = 1'b1;
        dec.regWrite = 1'b1;
        dec.dstRt    = 1'b1;
        dec.aluSrcB  = 1'b1;
      end
      OP_SW: begin
        dec.memWrite = 1'b1;
        dec.aluSrcB  = 1'b1;
      end
      OP_BEQ:  dec.branch  = 1'b1;
      OP_J:    dec.jump    = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
    // Writes to $zero are architecturally discarded, so never request them.
    destReg = dec.dstRt ? rt : rd;
    if (destReg == 5'd0) dec.regWrite = 1'b0;
    immExt = zeroExt ? DATA_W'(imm16) : DATA_W'($signed(imm16));
  end

  // Pipeline registers and saturating illegal counter; flush drops both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      aValid            <= 1'b0;
      aInstr            <= '0;
      aPc               <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_pc        <= '0;
      bus.out_rs        <= '0;
      bus.out_rt        <= '0;
      bus.out_rd        <= '0;
      bus.out_imm       <= '0;
      bus.out_alu_src_b <= 1'b0;
      bus.out_reg_write <= 1'b0;
      bus.out_dst_rt    <= 1'b0;
      bus.out_mem_read  <= 1'b0;
      bus.out_mem_write <= 1'b0;
      bus.out_branch    <= 1'b0;
      bus.out_jump      <= 1'b0;
      bus.out_illegal   <= 1'b0;
      bus.illegal_cnt   <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready && bus.out_illegal && !bus.flush &&
          bus.illegal_cnt != CNT_MAX) begin
        bus.illegal_cnt <= bus.illegal_cnt + CNT_W'(1);
      end
      if (bus.flush) begin
        aValid        <= 1'b0;
        bus.out_valid <= 1'b0;
      end else begin
        if (bAdvance) begin
          bus.out_valid <= aValid;
          if (aValid) begin
            bus.out_pc        <= aPc;
            bus.out_rs        <= rs;
            bus.out_rt        <= rt;
            bus.out_rd        <= rd;
            bus.out_imm       <= immExt;
            bus.out_alu_src_b <= dec.aluSrcB;
            bus.out_reg_write <= dec.regWrite;
            bus.out_dst_rt    <= dec.dstRt;
            bus.out_mem_read  <= dec.memRead;
            bus.out_mem_write <= dec.memWrite;
            bus.out_branch    <= dec.branch;
            bus.out_jump      <= dec.jump;
            bus.out_illegal   <= dec.illegal;
          end
        end
        if (inReady) begin
          aValid <= bus.in_valid;
          if (bus.in_valid) begin
            aInstr <= bus.in_instr;
            aPc    <= bus.in_pc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe: hand-computed decode vectors, stall,
// flush, illegal-counter saturation and mid-run reset.
module tb_id_decode_pipe;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 2;

  // Control vector order: {alu_src_b, reg_write, dst_rt, mem_read, mem_write, branch, jump, illegal}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_RTY  = 8'b0100_0000;
  localparam logic [7:0] C_IMM  = 8'b1110_0000;
  localparam logic [7:0] C_IMM0 = 8'b1010_0000;
  localparam logic [7:0] C_LW   = 8'b1111_0000;
  localparam logic [7:0] C_SW   = 8'b1000_1000;
  localparam logic [7:0] C_BEQ  = 8'b0000_0100;
  localparam logic [7:0] C_J    = 8'b0000_0010;
  localparam logic [7:0] C_ILL  = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  id_decode_pipe_if #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_decode_pipe #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ctrlNow();
    return {bus.out_alu_src_b, bus.out_reg_write, bus.out_dst_rt, bus.out_mem_read,
            bus.out_mem_write, bus.out_branch, bus.out_jump, bus.out_illegal};
  endfunction

  // Full bundle check of a valid output.
  task automatic chkB(input string tag, input logic [31:0] pc, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] imm, input logic [7:0] ctrl);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'(1));
    chk({tag, ".pc"}, 64'(bus.out_pc), 64'(pc));
    chk({tag, ".regs"}, 64'({bus.out_rs, bus.out_rt, bus.out_rd}), 64'({rs, rt, rd}));
    chk({tag, ".imm"}, 64'(bus.out_imm), 64'(imm));
    chk({tag, ".ctrl"}, 64'(ctrlNow()), 64'(ctrl));
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, ".pc"}, 64'(bus.out_pc), 64'(0));
    chk({tag, ".regs"}, 64'({bus.out_rs, bus.out_rt, bus.out_rd}), 64'(0));
    chk({tag, ".imm"}, 64'(bus.out_imm), 64'(0));
    chk({tag, ".ctrl"}, 64'(ctrlNow()), 64'(C_NONE));
    chk({tag, ".cnt"}, 64'(bus.illegal_cnt), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    chkAllZero("reset");
    chk("reset.in_ready", 64'(bus.in_ready), 64'(1));

    // addi $8,$0,-1: two-cycle latency, sign-extended immediate
    drive(1'b1, 32'h2008FFFF, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("addi.lat1", 64'(bus.out_valid), 64'(0));
    tick();
    chkB("addi", 32'h100, 5'd0, 5'd8, 5'd31, 32'hFFFFFFFF, C_IMM);

    // ori zero-extends; sw has no register write
    drive(1'b1, 32'h3508FFFF, 32'h104);
    tick();
    drive(1'b1, 32'hAD090004, 32'h108);
    tick();
    chkB("ori", 32'h104, 5'd8, 5'd8, 5'd31, 32'h0000FFFF, C_IMM);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chkB("sw", 32'h108, 5'd8, 5'd9, 5'd0, 32'h00000004, C_SW);
    tick();
    chk("sw.drain", 64'(bus.out_valid), 64'(0));

    // R-type stream with a three-cycle EX stall
    drive(1'b1, 32'h00221800, 32'h200);
    tick();
    drive(1'b1, 32'h00222000, 32'h204);
    tick();
    chkB("r0", 32'h200, 5'd1, 5'd2, 5'd3, 32'h00001800, C_RTY);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00222800, 32'h208);
    #1;
    chk("stall.in_ready", 64'(bus.in_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chkB($sformatf("stall%0d", i), 32'h200, 5'd1, 5'd2, 5'd3, 32'h00001800, C_RTY);
      chk($sformatf("stall%0d.in_ready", i), 64'(bus.in_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall.in_ready", 64'(bus.in_ready), 64'(1));
    tick();
    chkB("r1", 32'h204, 5'd1, 5'd2, 5'd4, 32'h00002000, C_RTY);
    drive(1'b1, 32'h00223000, 32'h20C);
    tick();
    chkB("r2", 32'h208, 5'd1, 5'd2, 5'd5, 32'h00002800, C_RTY);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chkB("r3", 32'h20C, 5'd1, 5'd2, 5'd6, 32'h00003000, C_RTY);
    tick();
    chk("stream.drain", 64'(bus.out_valid), 64'(0));

    // Flush with both stages full and a new word offered
    drive(1'b1, 32'h00221800, 32'h300);
    tick();
    drive(1'b1, 32'h00222000, 32'h304);
    tick();
    chk("preflush.valid", 64'(bus.out_valid), 64'(1));
    drive(1'b1, 32'h00222800, 32'h308);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush.valid", 64'(bus.out_valid), 64'(0));
    chk("flush.in_ready", 64'(bus.in_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flush.after%0d", i), 64'(bus.out_valid), 64'(0));
    end

    // Illegal opcode 0x3F stream; 2-bit counter saturates at 3
    drive(1'b1, 32'hFC221800, 32'h400);
    tick();
    tick();
    chkB("ill0", 32'h400, 5'd1, 5'd2, 5'd3, 32'h00001800, C_ILL);
    chk("ill0.cnt", 64'(bus.illegal_cnt), 64'(0));
    tick();
    chk("ill1.cnt", 64'(bus.illegal_cnt), 64'(1));
    tick();
    chk("ill2.cnt", 64'(bus.illegal_cnt), 64'(2));
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("ill3.cnt", 64'(bus.illegal_cnt), 64'(3));
    chk("ill3.valid", 64'(bus.out_valid), 64'(1));
    tick();
    chk("ill.sat", 64'(bus.illegal_cnt), 64'(3));
    chk("ill.drain", 64'(bus.out_valid), 64'(0));

    // Remaining opcodes back-to-back, including writes to $zero
    drive(1'b1, 32'h1022FFFE, 32'h500);
    tick();
    drive(1'b1, 32'h8C2AFFF0, 32'h504);
    tick();
    chkB("beq", 32'h500, 5'd1, 5'd2, 5'd31, 32'hFFFFFFFE, C_BEQ);
    drive(1'b1, 32'h30208000, 32'h508);
    tick();
    chkB("lw", 32'h504, 5'd1, 5'd10, 5'd31, 32'hFFFFFFF0, C_LW);
    drive(1'b1, 32'h08000010, 32'h50C);
    tick();
    chkB("andi.rt0", 32'h508, 5'd1, 5'd0, 5'd16, 32'h00008000, C_IMM0);
    drive(1'b1, 32'h00000000, 32'h510);
    tick();
    chkB("j", 32'h50C, 5'd0, 5'd0, 5'd0, 32'h00000010, C_J);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chkB("nop.rd0", 32'h510, 5'd0, 5'd0, 5'd0, 32'h00000000, C_NONE);

    // Reset while B holds a bundle and an illegal count is pending
    drive(1'b1, 32'hFC221800, 32'h600);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("prerst.valid", 64'(bus.out_valid), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkAllZero("midrst");

    // A flushed illegal bundle is not counted even if EX is ready
    drive(1'b1, 32'hFC221800, 32'h700);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("flushill.valid", 64'(bus.out_illegal & bus.out_valid), 64'(1));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flushill.cnt", 64'(bus.illegal_cnt), 64'(0));
    tick();
    chk("flushill.cnt2", 64'(bus.illegal_cnt), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
